// File: rtl/adc_capture_pkg.sv
// Shared types and helpers for the ADC capture write sequencer.
// State encoding, default frame marker and sample bit-reverse.
package adc_capture_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_TRIG,
    S_HDR,
    S_CAPT,
    S_DRAIN
  } state_e;

  localparam logic [7:0] HDR_DEF = 8'h0A;

  // Board wiring puts ad[0] on the byte MSB.
  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_capture_ctrl_sync2.sv
// Two-flop synchronizer for the read-domain FIFO empty flag.
// Both flops reset to 0 (FIFO treated as not empty).
module sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/adc_capture_ctrl.sv
// Framed burst writer: header byte + SAMPLES bytes into the ADC FIFO.
// Define ADC_TRIG_EN to gate each frame on a rising trigger level.
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int unsigned SAMPLES = 256,
  parameter logic [7:0]  HEADER  = HDR_DEF,
  parameter int unsigned CNT_W   = 16
) (
  input  logic        ad_clk,
  input  logic        RST_n,
  input  logic        start,
  input  logic        continuous,
  input  logic [11:0] ad,
  input  logic [7:0]  trig_level,
  input  logic        fifo_full,
  input  logic        fifo_empty,
  output logic        fifo_wrreq,
  output logic [7:0]  fifo_data,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(SAMPLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       smp_q;
  logic [7:0]       cur_b;
  logic             empty_s;
  logic             wr_d;
  logic [7:0]       data_d;
  logic             busy_d;
  logic             done_d;
  logic             ovf_d;

  assign cur_b = bitrev8(ad[7:0]);

  sync2 u_sync2 (
    .clk_i  (ad_clk),
    .rst_ni (RST_n),
    .d_i    (fifo_empty),
    .q_o    (empty_s)
  );

`ifdef ADC_TRIG_EN
  logic trig_hit;
  logic unused_ok;
  assign trig_hit  = (smp_q < trig_level) &&
                     (cur_b >= trig_level);
  assign unused_ok = ^ad[11:8];
`else
  logic unused_ok;
  assign unused_ok = ^{ad[11:8], trig_level};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_ARM;
      end
      S_ARM: begin
        if (empty_s) begin
`ifdef ADC_TRIG_EN
          state_d = S_TRIG;
`else
          state_d = S_HDR;
`endif
        end
      end
`ifdef ADC_TRIG_EN
      S_TRIG: begin
        if (trig_hit) state_d = S_HDR;
      end
`endif
      S_HDR: begin
        state_d = S_CAPT;
        cnt_d   = '0;
      end
      S_CAPT: begin
        if (cnt_q == LAST) begin
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (empty_s) begin
          state_d = continuous ? S_ARM : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the state being entered,
  // so the strobe lines up with the HDR/CAPT cycles.
  always_comb begin
    wr_d   = 1'b0;
    data_d = fifo_data;
    done_d = 1'b0;
    ovf_d  = overflow;
    if (state_q == S_IDLE && start) ovf_d = 1'b0;
    if (state_d == S_HDR) begin
      data_d = HEADER;
    end else if (state_d == S_CAPT) begin
      data_d = smp_q;
    end
    if (state_d == S_HDR || state_d == S_CAPT) begin
      if (fifo_full) ovf_d = 1'b1;
      else           wr_d  = 1'b1;
    end
    if (state_q == S_DRAIN && empty_s) done_d = 1'b1;
    busy_d = (state_d != S_IDLE) || done_d;
  end

  always_ff @(posedge ad_clk) begin
    if (!RST_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      smp_q      <= '0;
      fifo_wrreq <= 1'b0;
      fifo_data  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      smp_q      <= cur_b;
      fifo_wrreq <= wr_d;
      fifo_data  <= data_d;
      busy       <= busy_d;
      done       <= done_d;
      overflow   <= ovf_d;
    end
  end

endmodule
